// File: rtl/lsu_mem_ctrl.sv
// Load/store control stage between EX/MEM and the data memory: accepts one
// request at a time, checks it, sequences the access and returns a registered result.
module lsu_mem_ctrl #(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_load,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] dm_addr,
    output logic        dm_we,
    output logic [2:0]  read_type,
    output logic [1:0]  write_type,
    output logic [31:0] dm_din,
    input  logic [31:0] dm_dout,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_exc,
    output logic [31:0] wb_exc_addr
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FAULT  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [AW-1:0]  addr_q;
    logic [RW-1:0]  rd_q;
    logic           is_load_q;
    logic           is_store_q;

    logic           legal;
    logic           misaligned;
    logic           req_ok;
    logic [2:0]     rtype_dec;
    logic [1:0]     wtype_dec;
    logic           accept;
    logic           done_ok;
    logic           done_exc;

    // funct3 decode and alignment check on the presented request
    always_comb begin
        legal      = 1'b0;
        misaligned = 1'b0;
        rtype_dec  = 3'd0;
        wtype_dec  = 2'd0;
        if (req_is_load && !req_is_store) begin
            case (req_funct3)
                3'b000: begin legal = 1'b1; rtype_dec = 3'd1; end
                3'b001: begin legal = 1'b1; rtype_dec = 3'd3; misaligned = req_addr[0]; end
                3'b010: begin legal = 1'b1; rtype_dec = 3'd0; misaligned = |req_addr[1:0]; end
                3'b100: begin legal = 1'b1; rtype_dec = 3'd2; end
                3'b101: begin legal = 1'b1; rtype_dec = 3'd4; misaligned = req_addr[0]; end
                default: legal = 1'b0;
            endcase
        end else if (req_is_store && !req_is_load) begin
            case (req_funct3)
                3'b000: begin legal = 1'b1; wtype_dec = 2'd1; end
                3'b001: begin legal = 1'b1; wtype_dec = 2'd2; misaligned = req_addr[0]; end
                3'b010: begin legal = 1'b1; wtype_dec = 2'd0; misaligned = |req_addr[1:0]; end
                default: legal = 1'b0;
            endcase
        end
        req_ok = legal && !misaligned;
    end

    // next-state and completion strobes; flush abandons any outstanding access
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        done_ok  = 1'b0;
        done_exc = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    accept  = 1'b1;
                    state_d = req_ok ? ACCESS : FAULT;
                end
            end
            ACCESS: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_ok = 1'b1;
                end
            end
            FAULT: begin
                state_d  = IDLE;
                done_exc = !flush;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    // write strobe is combinational so a flush or reset can kill it within the cycle
    assign dm_we     = (state_q == ACCESS) && (cnt_q == '0) && is_store_q && !flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q       <= '0;
            addr_q      <= '0;
            rd_q        <= '0;
            is_load_q   <= 1'b0;
            is_store_q  <= 1'b0;
            dm_addr     <= '0;
            dm_din      <= '0;
            read_type   <= '0;
            write_type  <= '0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            wb_exc      <= 1'b0;
            wb_exc_addr <= '0;
        end else begin
            wb_valid <= 1'b0;
            if (accept) begin
                addr_q     <= req_addr;
                rd_q       <= req_rd;
                is_load_q  <= req_is_load;
                is_store_q <= req_is_store;
                cnt_q      <= CNT_W'(WAIT_CYCLES);
                if (req_ok) begin
                    dm_addr    <= req_addr;
                    dm_din     <= req_wdata;
                    read_type  <= rtype_dec;
                    write_type <= wtype_dec;
                end
            end else if ((state_q == ACCESS) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (done_ok) begin
                wb_valid <= 1'b1;
                wb_exc   <= 1'b0;
                wb_rd    <= is_load_q ? rd_q : RW'(0);
                wb_data  <= is_load_q ? dm_dout : DW'(0);
            end
            if (done_exc) begin
                wb_valid    <= 1'b1;
                wb_exc      <= 1'b1;
                wb_exc_addr <= addr_q;
                wb_rd       <= '0;
                wb_data     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: three instances (WAIT_CYCLES 0/2/3) each backed by a
// small byte memory; expected write-backs are queued at issue and matched in order.
module tb_lsu_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic [2:0]  req_valid, flush;
    logic        req_is_load, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;

    logic [2:0]  req_ready, busy, dm_we, wb_valid, wb_exc;
    logic [31:0] dm_addr [3];
    logic [31:0] dm_din [3];
    logic [31:0] wb_data [3];
    logic [31:0] wb_exc_addr [3];
    logic [2:0]  read_type [3];
    logic [1:0]  write_type [3];
    logic [4:0]  wb_rd [3];

    int checks = 0;
    int failures = 0;
    int we_cnt [3] = '{0, 0, 0};
    logic [1:0] wt_at_we [3];
    logic [2:0] prev_wb = 3'b000;

    typedef struct {
        int          inst;
        logic        exc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] addr;
        logic        dbl;
    } wb_t;

    wb_t sb_q[$];
    wb_t obs_q[$];

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int unsigned WC = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
        logic [7:0]  mem [256];
        logic        wr_ok [256];
        logic [7:0]  byt [4];
        logic [31:0] dout;

        lsu_mem_ctrl #(.WAIT_CYCLES(WC), .CNT_W(4)) u_dut (
            .clk         (clk),
            .rstn        (rstn),
            .req_valid   (req_valid[g]),
            .req_ready   (req_ready[g]),
            .req_is_load (req_is_load),
            .req_is_store(req_is_store),
            .req_funct3  (req_funct3),
            .req_addr    (req_addr),
            .req_wdata   (req_wdata),
            .req_rd      (req_rd),
            .flush       (flush[g]),
            .busy        (busy[g]),
            .dm_addr     (dm_addr[g]),
            .dm_we       (dm_we[g]),
            .read_type   (read_type[g]),
            .write_type  (write_type[g]),
            .dm_din      (dm_din[g]),
            .dm_dout     (dout),
            .wb_valid    (wb_valid[g]),
            .wb_rd       (wb_rd[g]),
            .wb_data     (wb_data[g]),
            .wb_exc      (wb_exc[g]),
            .wb_exc_addr (wb_exc_addr[g])
        );

        // unwritten bytes read as addr ^ 0x5A
        always_comb begin : p_rd
            logic [7:0] ak;
            for (int k = 0; k < 4; k++) begin
                ak = dm_addr[g][7:0] + 8'(k);
                byt[k] = (wr_ok[ak] === 1'b1) ? mem[ak] : (ak ^ 8'h5A);
            end
            case (read_type[g])
                3'd0:    dout = {byt[3], byt[2], byt[1], byt[0]};
                3'd1:    dout = {{24{byt[0][7]}}, byt[0]};
                3'd2:    dout = {24'h0, byt[0]};
                3'd3:    dout = {{16{byt[1][7]}}, byt[1], byt[0]};
                3'd4:    dout = {16'h0, byt[1], byt[0]};
                default: dout = 32'h0;
            endcase
        end

        always @(posedge clk) begin
            if (dm_we[g] === 1'b1) begin
                for (int k = 0; k < 4; k++) begin
                    if (k == 0 || (k == 1 && write_type[g] != 2'd1) || write_type[g] == 2'd0) begin
                        mem[8'(dm_addr[g][7:0] + 8'(k))]   <= dm_din[g][8*k +: 8];
                        wr_ok[8'(dm_addr[g][7:0] + 8'(k))] <= 1'b1;
                    end
                end
            end
        end
    end

    // capture write-backs and write strobes away from the active edge
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (dm_we[i] === 1'b1) begin
                we_cnt[i]++;
                wt_at_we[i] = write_type[i];
            end
            if (wb_valid[i] === 1'b1) begin
                obs_q.push_back('{i, wb_exc[i], wb_rd[i], wb_data[i], wb_exc_addr[i], prev_wb[i]});
            end
        end
        prev_wb = wb_valid;
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wb(int i, logic exc, logic [4:0] rd, logic [31:0] data, logic [31:0] addr);
        sb_q.push_back('{i, exc, rd, data, addr, 1'b0});
    endtask

    // drive one request into instance i; returns 1ns after the accepting edge
    task automatic issue(int i, bit ld, bit st, logic [2:0] f3, logic [31:0] a,
                         logic [31:0] wd, logic [4:0] rd);
        int n = 0;
        while (req_ready[i] !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk($sformatf("ready_before_issue_i%0d", i), 32'(req_ready[i]), 32'd1);
        req_is_load  = ld;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = a;
        req_wdata    = wd;
        req_rd       = rd;
        req_valid[i] = 1'b1;
        step();
        req_valid[i] = 1'b0;
    endtask

    // wait for instance i to go idle, then match observed write-backs in order
    task automatic drain(int i, string tag);
        int n = 0;
        wb_t e, o;
        while ((busy[i] !== 1'b0 || obs_q.size() < sb_q.size()) && n < 100) begin
            step();
            n++;
        end
        step();
        step();
        while (sb_q.size() > 0 && obs_q.size() > 0) begin
            e = sb_q.pop_front();
            o = obs_q.pop_front();
            chk({tag, "_inst"}, 32'(o.inst), 32'(e.inst));
            chk({tag, "_exc"},  32'(o.exc),  32'(e.exc));
            chk({tag, "_rd"},   32'(o.rd),   32'(e.rd));
            chk({tag, "_data"}, o.data, e.data);
            chk({tag, "_pulse"}, 32'(o.dbl), 32'd0);
            if (e.exc) chk({tag, "_exc_addr"}, o.addr, e.addr);
        end
        chk({tag, "_missing"}, 32'(sb_q.size()), 32'd0);
        chk({tag, "_extra"},   32'(obs_q.size()), 32'd0);
        sb_q.delete();
        obs_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        rstn = 1'b0;
        req_valid = 3'b000;
        flush = 3'b000;
        req_is_load = 1'b0;
        req_is_store = 1'b0;
        req_funct3 = 3'd0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        req_rd = 5'd0;
        #12;
        for (int i = 0; i < 3; i++) begin
            chk("rst_ready",   32'(req_ready[i]), 32'd1);
            chk("rst_busy",    32'(busy[i]), 32'd0);
            chk("rst_we",      32'(dm_we[i]), 32'd0);
            chk("rst_wbvalid", 32'(wb_valid[i]), 32'd0);
            chk("rst_dmaddr",  dm_addr[i], 32'h0);
            chk("rst_wbdata",  wb_data[i], 32'h0);
        end
        @(negedge clk);
        rstn = 1'b1;
        step();

        // sw then lw, no wait states
        w0 = we_cnt[0];
        expect_wb(0, 1'b0, 5'd0, 32'h0, 32'h0);
        issue(0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd9);
        chk("sw_we",     32'(dm_we[0]), 32'd1);
        chk("sw_addr",   dm_addr[0], 32'h10);
        chk("sw_din",    dm_din[0], 32'hDEADBEEF);
        chk("sw_wtype",  32'(write_type[0]), 32'd0);
        drain(0, "sw");
        chk("sw_we_count", 32'(we_cnt[0] - w0), 32'd1);
        expect_wb(0, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0);
        issue(0, 1, 0, 3'b010, 32'h10, 32'h0, 5'd5);
        step();
        chk("lw_latency", 32'(wb_valid[0]), 32'd1);
        drain(0, "lw");

        // sb then byte loads
        w0 = we_cnt[0];
        expect_wb(0, 1'b0, 5'd0, 32'h0, 32'h0);
        issue(0, 0, 1, 3'b000, 32'h13, 32'hFFFFFFAB, 5'd2);
        chk("sb_wtype", 32'(write_type[0]), 32'd1);
        drain(0, "sb");
        chk("sb_we_count", 32'(we_cnt[0] - w0), 32'd1);
        chk("sb_wt_at_we", 32'(wt_at_we[0]), 32'd1);
        expect_wb(0, 1'b0, 5'd3, 32'h000000AB, 32'h0);
        issue(0, 1, 0, 3'b100, 32'h13, 32'h0, 5'd3);
        drain(0, "lbu");
        expect_wb(0, 1'b0, 5'd4, 32'hFFFFFFAB, 32'h0);
        issue(0, 1, 0, 3'b000, 32'h13, 32'h0, 5'd4);
        drain(0, "lb");
        expect_wb(0, 1'b0, 5'd4, 32'h000000AD, 32'h0);
        issue(0, 1, 0, 3'b100, 32'h12, 32'h0, 5'd4);
        drain(0, "lbu_neighbour");

        // faults: misaligned and illegal requests
        w0 = we_cnt[0];
        expect_wb(0, 1'b1, 5'd0, 32'h0, 32'h21);
        issue(0, 1, 0, 3'b001, 32'h21, 32'h0, 5'd8);
        step();
        chk("lh_mis_valid", 32'(wb_valid[0]), 32'd1);
        chk("lh_mis_exc",   32'(wb_exc[0]), 32'd1);
        drain(0, "lh_mis");
        expect_wb(0, 1'b1, 5'd0, 32'h0, 32'h30);
        issue(0, 1, 0, 3'b011, 32'h30, 32'h0, 5'd8);
        drain(0, "ld_f3_illegal");
        expect_wb(0, 1'b1, 5'd0, 32'h0, 32'h34);
        issue(0, 1, 1, 3'b010, 32'h34, 32'h0, 5'd8);
        drain(0, "both_flags");
        expect_wb(0, 1'b1, 5'd0, 32'h0, 32'h50);
        issue(0, 0, 0, 3'b010, 32'h50, 32'h0, 5'd8);
        drain(0, "no_flags");
        expect_wb(0, 1'b1, 5'd0, 32'h0, 32'h42);
        issue(0, 0, 1, 3'b010, 32'h42, 32'h12345678, 5'd0);
        drain(0, "sw_mis");
        chk("fault_we_count", 32'(we_cnt[0] - w0), 32'd0);
        expect_wb(0, 1'b0, 5'd1, 32'h79787B7A, 32'h0);
        issue(0, 1, 0, 3'b010, 32'h20, 32'h0, 5'd1);
        drain(0, "lw_after_fault");

        // WAIT_CYCLES=3: flush while counter==1
        w0 = we_cnt[2];
        issue(2, 0, 1, 3'b010, 32'h40, 32'hCAFEF00D, 5'd0);
        step();
        step();
        flush[2] = 1'b1;
        chk("flush_mid_we", 32'(dm_we[2]), 32'd0);
        step();
        flush[2] = 1'b0;
        chk("flush_mid_ready",   32'(req_ready[2]), 32'd1);
        chk("flush_mid_busy",    32'(busy[2]), 32'd0);
        chk("flush_mid_wbvalid", 32'(wb_valid[2]), 32'd0);
        drain(2, "flush_mid");
        chk("flush_mid_we_count", 32'(we_cnt[2] - w0), 32'd0);
        expect_wb(2, 1'b0, 5'd11, 32'h19181B1A, 32'h0);
        issue(2, 1, 0, 3'b010, 32'h40, 32'h0, 5'd11);
        drain(2, "lw_after_flush");

        // flush in the final ACCESS cycle suppresses the write
        w0 = we_cnt[2];
        issue(2, 0, 1, 3'b010, 32'h48, 32'hCAFEF00D, 5'd0);
        step();
        step();
        step();
        flush[2] = 1'b1;
        #1;
        chk("flush_last_we", 32'(dm_we[2]), 32'd0);
        step();
        flush[2] = 1'b0;
        drain(2, "flush_last");
        chk("flush_last_we_count", 32'(we_cnt[2] - w0), 32'd0);
        expect_wb(2, 1'b0, 5'd12, 32'h11101312, 32'h0);
        issue(2, 1, 0, 3'b010, 32'h48, 32'h0, 5'd12);
        drain(2, "lw_after_flush_last");

        // flush in IDLE blocks acceptance
        flush[2] = 1'b1;
        req_is_load = 1'b1;
        req_is_store = 1'b0;
        req_funct3 = 3'b010;
        req_addr = 32'h40;
        req_valid[2] = 1'b1;
        step();
        req_valid[2] = 1'b0;
        flush[2] = 1'b0;
        chk("flush_idle_busy", 32'(busy[2]), 32'd0);
        drain(2, "flush_idle");

        // WAIT_CYCLES=2: two loads back-to-back with req_valid held
        expect_wb(1, 1'b0, 5'd6, 32'hD9D8DBDA, 32'h0);
        expect_wb(1, 1'b0, 5'd7, 32'hFFFFDDDC, 32'h0);
        req_is_load = 1'b1;
        req_is_store = 1'b0;
        req_funct3 = 3'b010;
        req_addr = 32'h80;
        req_rd = 5'd6;
        req_valid[1] = 1'b1;
        step();
        req_funct3 = 3'b001;
        req_addr = 32'h86;
        req_rd = 5'd7;
        chk("b2b_busy_c0", 32'(busy[1]), 32'd1);
        step();
        chk("b2b_busy_c1", 32'(busy[1]), 32'd1);
        step();
        chk("b2b_busy_c2", 32'(busy[1]), 32'd1);
        step();
        chk("b2b_wb1_valid", 32'(wb_valid[1]), 32'd1);
        chk("b2b_wb1_ready", 32'(req_ready[1]), 32'd1);
        chk("b2b_wb1_busy",  32'(busy[1]), 32'd0);
        step();
        chk("b2b_second_accept", 32'(busy[1]), 32'd1);
        req_valid[1] = 1'b0;
        drain(1, "b2b");

        // reset asserted during the write cycle of a store
        w0 = we_cnt[2];
        issue(2, 0, 1, 3'b010, 32'h44, 32'h55667788, 5'd0);
        step();
        step();
        step();
        chk("rst_mid_we_before", 32'(dm_we[2]), 32'd1);
        #1;
        rstn = 1'b0;
        #1;
        chk("rst_mid_we",       32'(dm_we[2]), 32'd0);
        chk("rst_mid_busy",     32'(busy[2]), 32'd0);
        chk("rst_mid_ready",    32'(req_ready[2]), 32'd1);
        chk("rst_mid_addr",     dm_addr[2], 32'h0);
        chk("rst_mid_din",      dm_din[2], 32'h0);
        chk("rst_mid_wbvalid",  32'(wb_valid[2]), 32'd0);
        chk("rst_mid_wbdata",   wb_data[2], 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        step();
        chk("rst_release_ready", 32'(req_ready[2]), 32'd1);
        chk("rst_mid_we_count",  32'(we_cnt[2] - w0), 32'd0);
        expect_wb(2, 1'b0, 5'd13, 32'h1D1C1F1E, 32'h0);
        issue(2, 1, 0, 3'b010, 32'h44, 32'h0, 5'd13);
        drain(2, "lw_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
